smp_ckt_tester: RTL
===================

# smp_ckt_tester

Self-checking stimulus/response block for the lab's 4-input sample circuit.
- Drives its D input through all 16 codes and samples its QX/QY outputs after a settle delay.
- Compares each sample with the golden function and reports a mismatch count, the first failing code and a pass flag.
- Sits on the opposite side of the sample circuit's interface: it is the source of D and the sink of QX/QY, so any variant of the circuit can be exercised on-board or in simulation.

## Interface
- G_SETTLE, default 1: number of idle cycles between driving a code and sampling QX/QY. Legal range 0..15.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  run request. Sampled only in IDLE.
- QX  in  1  circuit output under test.
- QY  in  1  circuit output under test.
- D  out  4  stimulus code to the circuit under test.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  one-cycle pulse at the end of a run.
- PASS  out  1  high after a run with zero mismatches. Held until the next accepted START.
- ERR_CNT  out  5  number of codes with any mismatch in the current/last run (0..16).
- FIRST_ERR  out  4  first code that mismatched.
- FIRST_ERR_VLD  out  1  FIRST_ERR is valid.

## Operation
- Golden function per code d:
  - n1 = d[0] & d[1]
  - QXexp = n1 | d[2]
  - QYexp = ~(QXexp | d[3])
- A code mismatches if QX != QXexp or QY != QYexp. A code counts once even if both outputs are wrong.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, FIN.
- IDLE:
  - START=1 at an edge → APPLY.
  - On acceptance, clear ERR_CNT, PASS and FIRST_ERR_VLD, and set D=0.
- APPLY: one cycle → SETTLE if G_SETTLE>0, else SAMPLE.
- SETTLE: holds for G_SETTLE cycles, using an internal 4-bit counter → SAMPLE.
- SAMPLE:
  - QX/QY are compared at the edge leaving SAMPLE.
  - On a mismatch: ERR_CNT increments. If FIRST_ERR_VLD=0, FIRST_ERR takes the current D and FIRST_ERR_VLD is set.
  - If D=15 → FIN. Otherwise D increments at the same edge → APPLY.
- FIN:
  - One cycle with DONE=1 and BUSY=0 → IDLE.
  - PASS is set at the edge entering FIN if the final ERR_CNT is 0. The final ERR_CNT includes the last code.
- BUSY=1 in APPLY, SETTLE and SAMPLE only.
- START is ignored outside IDLE, including in FIN. No queuing.
- D keeps the last code (15) after a run until the next START.
- ERR_CNT cannot exceed 16, so no saturation logic is needed.

## Timing
- Reset value of every output is 0: D, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR, FIRST_ERR_VLD. State is IDLE.
- RST_N low mid-run aborts immediately and asynchronously: all outputs go to 0 and state to IDLE. Leaving reset requires a fresh START.
- START accepted at edge t0 → BUSY and D=0 are visible after t0.
- Per code: G_SETTLE+2 cycles. D is stable for the whole window.
- DONE is high in the cycle after edge t0 + 16·(G_SETTLE+2).
  - 48 cycles for G_SETTLE=1.
  - 32 cycles for G_SETTLE=0.
- The circuit under test is purely combinational. With G_SETTLE=0, the path D→QX/QY must meet one clock period.
- ERR_CNT, FIRST_ERR and FIRST_ERR_VLD update at SAMPLE edges. They are stable from DONE until the next accepted START.

## Test plan
- Golden circuit (either mode), G_SETTLE=1, START pulse:
  - D steps 0..15, each held 3 cycles.
  - DONE occurs 48 cycles after acceptance.
  - ERR_CNT=0, PASS=1, FIRST_ERR_VLD=0.
- Faulty circuit with AND replaced by OR (QX=d0|d1|d2):
  - Codes 1, 2, 9 and 10 mismatch.
  - ERR_CNT=4, FIRST_ERR=1, FIRST_ERR_VLD=1, PASS=0.
- QY stuck-at-0:
  - Codes 0, 1 and 2 mismatch.
  - ERR_CNT=3, FIRST_ERR=0, PASS=0.
- G_SETTLE=0, golden circuit:
  - DONE occurs 32 cycles after acceptance.
  - DONE is high for exactly one cycle. BUSY is low in that cycle.
- START held high throughout a run:
  - No restart during BUSY or FIN.
  - A new run is accepted in the IDLE cycle after FIN.
  - ERR_CNT and PASS are cleared at that acceptance.
- RST_N pulsed low while D=5:
  - All outputs read 0 during reset.
  - A subsequent START restarts from D=0 and gives the correct final counts.

Source files
------------

// File: rtl/smp_ckt_tester.sv
// ============================================================================
// smp_ckt_tester : sweeps D through all 16 codes and checks QX/QY against the
//                  golden function, reporting mismatch count and first failure.
// Revision: 1.0
// ============================================================================
`default_nettype none

module smp_ckt_tester #(
    parameter int G_SETTLE = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       qx_i,
    input  logic       qy_i,
    output logic [3:0] d_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [4:0] err_cnt_o,
    output logic [3:0] first_err_o,
    output logic       first_err_vld_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_FIN    = 3'd4
    } state_e;

    localparam logic       HAS_SETTLE  = (G_SETTLE > 0);
    localparam logic [3:0] SETTLE_LAST = 4'((G_SETTLE > 0) ? G_SETTLE - 1 : 0);

    state_e     state_q, state_d;
    logic [3:0] d_q, d_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic [3:0] ferr_q, ferr_d;
    logic       fvld_q, fvld_d;
    logic       pass_q, pass_d;

    logic       qx_exp, qy_exp, mismatch;

    assign qx_exp   = (d_q[0] & d_q[1]) | d_q[2];
    assign qy_exp   = ~(qx_exp | d_q[3]);
    assign mismatch = (qx_i != qx_exp) | (qy_i != qy_exp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            d_q     <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            ferr_q  <= 4'd0;
            fvld_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            fvld_q  <= fvld_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        fvld_d  = fvld_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_APPLY;
                    d_d     = 4'd0;
                    err_d   = 5'd0;
                    fvld_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                cnt_d   = 4'd0;
                state_d = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!fvld_q) begin
                        ferr_d = d_q;
                        fvld_d = 1'b1;
                    end
                end
                // PASS must reflect the count including this last code
                if (d_q == 4'd15) begin
                    state_d = S_FIN;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    d_d     = d_q + 4'd1;
                    state_d = S_APPLY;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign d_o             = d_q;
    assign busy_o          = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                             (state_q == S_SAMPLE);
    assign done_o          = (state_q == S_FIN);
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_o     = ferr_q;
    assign first_err_vld_o = fvld_q;

endmodule

`default_nettype wire
